// File: rtl/m_rep_serializer.sv
// Reply-message serializer: two-entry message FIFO feeding a flit stream with head/tail markers.
// Optional `M_REP_SER_PARITY_EN adds a flit_par output (XOR of flit_out, 0 when idle).
module m_rep_serializer #(
    parameter int FLIT_W    = 16,
    parameter int MAX_FLITS = 9,
    parameter int LEN_W     = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [FLIT_W*MAX_FLITS-1:0] msg_in,
    input  logic                        v_msg_in,
    input  logic [LEN_W-1:0]            msg_len,
    output logic                        msg_rdy,
    output logic [FLIT_W-1:0]           flit_out,
    output logic                        v_flit_out,
    output logic                        head_out,
    output logic                        tail_out,
    input  logic                        out_rdy,
    output logic                        busy
`ifdef M_REP_SER_PARITY_EN
    ,
    output logic                        flit_par
`endif
);

    localparam int MSG_W = FLIT_W * MAX_FLITS;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_FLITS - 1);

    logic [MSG_W-1:0] ent_msg_q [2];
    logic [MSG_W-1:0] ent_msg_d [2];
    logic [LEN_W-1:0] ent_len_q [2];
    logic [LEN_W-1:0] ent_len_d [2];
    logic [1:0]       ent_vld_q, ent_vld_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0] sel_cnt_q, sel_cnt_d;

    logic             accept;
    logic             head_vld;
    logic             xfer;
    logic             last_flit;
    logic             pop;
    logic [LEN_W-1:0] len_clamped;
    logic [FLIT_W-1:0] flit_sel;

    // Ready depends only on registered occupancy, so a full buffer refuses even while popping.
    assign msg_rdy     = ~(ent_vld_q[0] & ent_vld_q[1]);
    assign accept      = v_msg_in & msg_rdy;
    assign head_vld    = ent_vld_q[rd_ptr_q] & ~rst;
    assign xfer        = head_vld & out_rdy;
    assign last_flit   = (sel_cnt_q == ent_len_q[rd_ptr_q]);
    assign pop         = xfer & last_flit;
    assign len_clamped = (msg_len > LEN_MAX) ? LEN_MAX : msg_len;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            ent_msg_d[i] = ent_msg_q[i];
            ent_len_d[i] = ent_len_q[i];
        end
        ent_vld_d = ent_vld_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        sel_cnt_d = sel_cnt_q;

        // Accept targets the tail slot and pop the head slot; they coincide only when
        // the buffer is empty (no pop) or full (no accept), so both may act together.
        if (accept) begin
            ent_msg_d[wr_ptr_q] = msg_in;
            ent_len_d[wr_ptr_q] = len_clamped;
            ent_vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d            = ~wr_ptr_q;
        end

        if (pop) begin
            ent_vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d            = ~rd_ptr_q;
            sel_cnt_d           = '0;
        end else if (xfer) begin
            sel_cnt_d = sel_cnt_q + LEN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                ent_msg_q[i] <= '0;
                ent_len_q[i] <= '0;
            end
            ent_vld_q <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            sel_cnt_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                ent_msg_q[i] <= ent_msg_d[i];
                ent_len_q[i] <= ent_len_d[i];
            end
            ent_vld_q <= ent_vld_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            sel_cnt_q <= sel_cnt_d;
        end
    end

    // Flit 0 is the most significant slice of the stored message.
    always_comb begin
        flit_sel = '0;
        for (int k = 0; k < MAX_FLITS; k++) begin
            if (sel_cnt_q == LEN_W'(k)) begin
                flit_sel = ent_msg_q[rd_ptr_q][MSG_W-1-k*FLIT_W -: FLIT_W];
            end
        end
    end

    assign v_flit_out = head_vld;
    assign flit_out   = head_vld ? flit_sel : '0;
    assign head_out   = head_vld & (sel_cnt_q == '0);
    assign tail_out   = head_vld & last_flit;
    assign busy       = (ent_vld_q[0] | ent_vld_q[1]) & ~rst;

`ifdef M_REP_SER_PARITY_EN
    assign flit_par = ^flit_out;
`endif

endmodule

// File: tb/tb_m_rep_serializer.sv
// Directed bench for m_rep_serializer (FLIT_W=16, MAX_FLITS=9); checks parity too when
// M_REP_SER_PARITY_EN is defined.
module tb_m_rep_serializer;

    logic         clk;
    logic         rst;
    logic [143:0] msg_in;
    logic         v_msg_in;
    logic [3:0]   msg_len;
    logic         msg_rdy;
    logic [15:0]  flit_out;
    logic         v_flit_out;
    logic         head_out;
    logic         tail_out;
    logic         out_rdy;
    logic         busy;
`ifdef M_REP_SER_PARITY_EN
    logic         flit_par;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    m_rep_serializer #(.FLIT_W(16), .MAX_FLITS(9), .LEN_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .msg_in     (msg_in),
        .v_msg_in   (v_msg_in),
        .msg_len    (msg_len),
        .msg_rdy    (msg_rdy),
        .flit_out   (flit_out),
        .v_flit_out (v_flit_out),
        .head_out   (head_out),
        .tail_out   (tail_out),
        .out_rdy    (out_rdy),
        .busy       (busy)
`ifdef M_REP_SER_PARITY_EN
        ,
        .flit_par   (flit_par)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Message whose flit k carries base+k, flit 0 in the top slice.
    function automatic logic [143:0] mk(input logic [15:0] base);
        logic [143:0] m;
        m = '0;
        for (int k = 0; k < 9; k++) m[143-k*16 -: 16] = base + 16'(k);
        return m;
    endfunction

    initial begin
        logic [143:0] m;
        int idx;

        // Reset, with a message offered during reset that must be ignored.
        rst = 1'b1; v_msg_in = 1'b1; msg_in = mk(16'h0100); msg_len = 4'd3; out_rdy = 1'b1;
        tick();
        check("rst_v", v_flit_out, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_flit", flit_out, 16'h0);
        tick();
        rst = 1'b0; v_msg_in = 1'b0;
        tick();
        check("post_rst_rdy", msg_rdy, 1'b1);
        check("post_rst_v", v_flit_out, 1'b0);
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_flit", flit_out, 16'h0);

        // Full-length message streams 0x0001..0x0009 from the next cycle.
        msg_in = mk(16'h0001); msg_len = 4'd8; v_msg_in = 1'b1;
        check("t1_rdy", msg_rdy, 1'b1);
        tick();
        v_msg_in = 1'b0;
        for (int k = 0; k < 9; k++) begin
            check("t1_v", v_flit_out, 1'b1);
            check("t1_flit", flit_out, 32'(16'h0001 + 16'(k)));
            check("t1_head", head_out, (k == 0));
            check("t1_tail", tail_out, (k == 8));
            tick();
        end
        check("t1_end_v", v_flit_out, 1'b0);
        check("t1_end_busy", busy, 1'b0);

        // Single-flit message.
        m = mk(16'h1110); m[143:128] = 16'hABCD;
        msg_in = m; msg_len = 4'd0; v_msg_in = 1'b1;
        tick();
        v_msg_in = 1'b0;
        check("t2_flit", flit_out, 16'hABCD);
        check("t2_head", head_out, 1'b1);
        check("t2_tail", tail_out, 1'b1);
        check("t2_busy", busy, 1'b1);
        tick();
        check("t2_busy_drop", busy, 1'b0);
        check("t2_v_drop", v_flit_out, 1'b0);

        // Back-pressure: fill both slots, third message waits until the first pops.
        out_rdy = 1'b0;
        msg_in = mk(16'hA000); msg_len = 4'd1; v_msg_in = 1'b1;
        tick();
        msg_in = mk(16'hB000); msg_len = 4'd0;
        check("t3_rdy_one", msg_rdy, 1'b1);
        tick();
        msg_in = mk(16'hC000); msg_len = 4'd0;
        check("t3_rdy_full", msg_rdy, 1'b0);
        check("t3_a0", flit_out, 16'hA000);
        check("t3_a0_head", head_out, 1'b1);
        tick();
        check("t3_a0_hold", flit_out, 16'hA000);
        check("t3_rdy_hold", msg_rdy, 1'b0);
        out_rdy = 1'b1;
        tick();
        check("t3_a1", flit_out, 16'hA001);
        check("t3_a1_tail", tail_out, 1'b1);
        check("t3_a1_head", head_out, 1'b0);
        check("t3_rdy_pop_full", msg_rdy, 1'b0);
        tick();
        check("t3_b0", flit_out, 16'hB000);
        check("t3_b0_ht", {head_out, tail_out}, 2'b11);
        check("t3_rdy_after_pop", msg_rdy, 1'b1);
        tick();
        v_msg_in = 1'b0;
        check("t3_c0", flit_out, 16'hC000);
        check("t3_c0_ht", {head_out, tail_out}, 2'b11);
        check("t3_c_busy", busy, 1'b1);
        tick();
        check("t3_drained", busy, 1'b0);

        // Toggling out_rdy during a 5-flit message.
        out_rdy = 1'b0;
        msg_in = mk(16'h5000); msg_len = 4'd4; v_msg_in = 1'b1;
        tick();
        v_msg_in = 1'b0;
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            out_rdy = (c % 2 == 1);
            check("t4_flit", flit_out, 32'(16'h5000 + 16'(idx)));
            check("t4_head", head_out, (idx == 0));
            check("t4_tail", tail_out, (idx == 4));
            if (out_rdy) idx++;
            tick();
        end
        check("t4_end_v", v_flit_out, 1'b0);
        check("t4_end_busy", busy, 1'b0);
        out_rdy = 1'b1;

        // Reset mid-message, then a fresh message starts at flit 0.
        msg_in = mk(16'h3000); msg_len = 4'd8; v_msg_in = 1'b1;
        tick();
        v_msg_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("t5_flit", flit_out, 32'(16'h3000 + 16'(k)));
            tick();
        end
        check("t5_flit3", flit_out, 16'h3003);
        rst = 1'b1;
        tick();
        check("t5_rst_v", v_flit_out, 1'b0);
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_flit", flit_out, 16'h0);
        rst = 1'b0;
        tick();
        check("t5_rdy", msg_rdy, 1'b1);
        check("t5_idle", v_flit_out, 1'b0);
        msg_in = mk(16'h7700); msg_len = 4'd1; v_msg_in = 1'b1;
        tick();
        v_msg_in = 1'b0;
        check("t5_new0", flit_out, 16'h7700);
        check("t5_new0_head", head_out, 1'b1);
        tick();
        check("t5_new1", flit_out, 16'h7701);
        check("t5_new1_tail", tail_out, 1'b1);
        tick();
        check("t5_end_busy", busy, 1'b0);

        // Oversized length is clamped to nine flits.
        msg_in = mk(16'h0001); msg_len = 4'd15; v_msg_in = 1'b1;
        tick();
        v_msg_in = 1'b0;
        for (int k = 0; k < 9; k++) begin
            check("t6_flit", flit_out, 32'(16'h0001 + 16'(k)));
            check("t6_tail", tail_out, (k == 8));
`ifdef M_REP_SER_PARITY_EN
            if (k == 2) check("t6_par_0003", flit_par, 1'b0);
            if (k == 6) check("t6_par_0007", flit_par, 1'b1);
`endif
            tick();
        end
        check("t6_end_v", v_flit_out, 1'b0);
        check("t6_end_busy", busy, 1'b0);
`ifdef M_REP_SER_PARITY_EN
        check("t6_par_idle", flit_par, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/m_rep_serializer.md
M_REP_SERIALIZER -- requirements
Module: m_rep_serializer

Interface
REQ-001 Parameter FLIT_W, default 16, width in bits of one output flit.
REQ-002 Parameter MAX_FLITS, default 9, maximum flits per message; MSG_W = FLIT_W*MAX_FLITS.
REQ-003 Parameter LEN_W, default 4, width of length field and flit counter; SHALL satisfy 2**LEN_W >= MAX_FLITS.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 msg_in  input  MSG_W  reply message; flit k = msg_in[MSG_W-1-k*FLIT_W -: FLIT_W], so flit 0 is the top slice.
REQ-007 v_msg_in  input  1  msg_in/msg_len valid.
REQ-008 msg_len  input  LEN_W  flit count minus one, sampled with msg_in.
REQ-009 msg_rdy  output  1  block can accept a message this cycle.
REQ-010 flit_out  output  FLIT_W  current flit.
REQ-011 v_flit_out  output  1  flit_out valid.
REQ-012 head_out  output  1  flit_out is flit 0 of its message.
REQ-013 tail_out  output  1  flit_out is the last flit of its message.
REQ-014 out_rdy  input  1  downstream FIFO accepts flit_out this cycle.
REQ-015 busy  output  1  at least one message buffered.

Function
REQ-016 Two-entry message buffer, FIFO order; each entry holds message, clamped length and valid bit.
REQ-017 Accept = v_msg_in && msg_rdy; on accept, msg_in and length are written to the tail entry at the next edge.
REQ-018 msg_rdy = 1 when fewer than 2 entries are valid; it is combinational from registered occupancy only, never from out_rdy.
REQ-019 msg_len > MAX_FLITS-1 is clamped to MAX_FLITS-1 on capture.
REQ-020 v_flit_out = head entry valid; flit_out = flit sel_cnt of head entry; both independent of out_rdy.
REQ-021 Transfer = v_flit_out && out_rdy; on transfer, sel_cnt increments.
REQ-022 On transfer with sel_cnt == head length: head entry is popped, sel_cnt <= 0, tail_out = 1 that cycle.
REQ-023 head_out = v_flit_out && sel_cnt == 0; for a length-0 message, head_out and tail_out are both 1.
REQ-024 Latency: message accepted in cycle N into an empty buffer shows flit 0 valid in cycle N+1.
REQ-025 Accept and pop in the same cycle: both take effect; occupancy unchanged; order preserved.
REQ-026 When full, msg_rdy = 0 even if a pop occurs that cycle; no same-cycle bypass.
REQ-027 out_rdy low holds flit_out, head_out, tail_out, sel_cnt stable; no flit is dropped or repeated.
REQ-028 When v_flit_out = 0, flit_out = 0, head_out = 0, tail_out = 0.
REQ-029 Pointers wrap modulo 2; sel_cnt never exceeds MAX_FLITS-1.

Reset
REQ-030 rst clears all entry valid bits, data, pointers and sel_cnt; messages in flight are discarded without a tail.
REQ-031 During and the cycle after rst: msg_rdy = 1 from the first cycle after rst deasserts; v_flit_out = 0, busy = 0, flit_out = 0.
REQ-032 v_msg_in asserted while rst = 1 is ignored.

Configuration
REQ-033 Macro M_REP_SER_PARITY_EN: when defined, output flit_par (1 bit) = even parity (XOR) of flit_out, 0 when v_flit_out = 0.
REQ-034 Without M_REP_SER_PARITY_EN, flit_par port and logic are absent; all other behaviour identical.

Verification (FLIT_W=16, MAX_FLITS=9)
REQ-035 Reset, then msg_in = 0x0001_0002_..._0009, msg_len = 8, out_rdy = 1 -> flits 0x0001..0x0009 on 9 consecutive cycles starting at N+1; head on 0x0001; tail on 0x0009.
REQ-036 msg_len = 0, msg top flit 0xABCD -> one flit 0xABCD with head_out = tail_out = 1; busy drops the next cycle.
REQ-037 Three back-to-back messages with out_rdy = 0 -> first two accepted, msg_rdy = 0 on the third; release out_rdy -> messages drain in order, the third is accepted after the first pops.
REQ-038 Toggle out_rdy every cycle during a 5-flit message -> each flit is held while out_rdy = 0; exactly 5 transfers, no duplicates.
REQ-039 Assert rst mid-message at flit 3 -> next cycle v_flit_out = 0, busy = 0; a new message then starts from its flit 0.
REQ-040 msg_len = 15 -> 9 flits sent (clamped); with M_REP_SER_PARITY_EN, flit 0x0003 gives flit_par = 0 and flit 0x0007 gives flit_par = 1.
